// File: rtl/serial_bin2bcd_8bit.sv
// Serial double-dabble binary-to-BCD converter with a parallel-load operand shift register.
// Optional registered completion flag on port done when DD_DONE_EN is defined.
module serial_bin2bcd_8bit #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              clear_bar,
    input  logic              preset_bar,
    input  logic              mode,
    input  logic [DATA_W-1:0] parallel_in,
    input  logic              serial_in,
    output logic              serial_out,
`ifdef DD_DONE_EN
    output logic              done,
`endif
    output logic [3:0]        d0,
    output logic [3:0]        d1,
    output logic [3:0]        d2
);

    localparam int unsigned CntW = $clog2(DATA_W + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(DATA_W);

    logic [DATA_W-1:0] sr_q, sr_d;
    logic [11:0]       dig_q, dig_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [11:0]       dig_adj;
`ifdef DD_DONE_EN
    logic              done_q, done_d;
`endif

    // Add-3 correction per digit ahead of the shift; 4-bit wrap, no carry between digits.
    always_comb begin
        dig_adj = dig_q;
        for (int i = 0; i < 3; i++) begin
            if (dig_q[i*4 +: 4] >= 4'd5) begin
                dig_adj[i*4 +: 4] = dig_q[i*4 +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        sr_d  = sr_q;
        dig_d = dig_q;
        cnt_d = cnt_q;
`ifdef DD_DONE_EN
        done_d = done_q;
`endif
        if (!preset_bar) begin
            sr_d  = '1;
            dig_d = '0;
            cnt_d = '0;
`ifdef DD_DONE_EN
            done_d = 1'b0;
`endif
        end else if (mode) begin
            sr_d  = parallel_in;
            dig_d = '0;
            cnt_d = '0;
`ifdef DD_DONE_EN
            done_d = 1'b0;
`endif
        end else begin
            sr_d = (sr_q << 1) | DATA_W'(serial_in);
            if (cnt_q < CntMax) begin
                dig_d = {dig_adj[10:0], sr_q[DATA_W-1]};
                cnt_d = cnt_q + CntW'(1);
`ifdef DD_DONE_EN
                done_d = (cnt_q == CntMax - CntW'(1));
`endif
            end
        end
    end

    // Clear overrides everything; the operand register still follows mode so a
    // load can be held under clear.
    always_ff @(posedge clk) begin
        if (!clear_bar) begin
            sr_q  <= mode ? parallel_in : '0;
            dig_q <= '0;
            cnt_q <= '0;
`ifdef DD_DONE_EN
            done_q <= 1'b0;
`endif
        end else begin
            sr_q  <= sr_d;
            dig_q <= dig_d;
            cnt_q <= cnt_d;
`ifdef DD_DONE_EN
            done_q <= done_d;
`endif
        end
    end

    assign serial_out = sr_q[DATA_W-1];
    assign d0 = dig_q[3:0];
    assign d1 = dig_q[7:4];
    assign d2 = dig_q[11:8];
`ifdef DD_DONE_EN
    assign done = done_q;
`endif

endmodule

// File: tb/tb_serial_bin2bcd_8bit.sv
// Directed self-checking bench for serial_bin2bcd_8bit (checks done when DD_DONE_EN is defined).
module tb_serial_bin2bcd_8bit;

    logic       clk = 1'b0;
    logic       clear_bar = 1'b0;
    logic       preset_bar = 1'b1;
    logic       mode = 1'b1;
    logic [7:0] parallel_in = 8'h00;
    logic       serial_in = 1'b0;
    logic       serial_out;
    logic [3:0] d0, d1, d2;
`ifdef DD_DONE_EN
    logic       done;
`endif

    int errors = 0;
    int checks = 0;

    serial_bin2bcd_8bit #(.DATA_W(8)) dut (
        .clk        (clk),
        .clear_bar  (clear_bar),
        .preset_bar (preset_bar),
        .mode       (mode),
        .parallel_in(parallel_in),
        .serial_in  (serial_in),
        .serial_out (serial_out),
`ifdef DD_DONE_EN
        .done       (done),
`endif
        .d0         (d0),
        .d1         (d1),
        .d2         (d2)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load_and_convert(input logic [7:0] val);
        clear_bar = 1'b0; preset_bar = 1'b1; mode = 1'b1; parallel_in = val; serial_in = 1'b0;
        tick(2);
        clear_bar = 1'b1; mode = 1'b0;
        tick(9);
    endtask

    task automatic test_reset;
        clear_bar = 1'b0; mode = 1'b1; parallel_in = 8'hB3;
        tick(2);
        checks++;
        if ({d2, d1, d0} !== 12'h000) begin
            errors++; $display("FAIL reset_digits: got %h want 000", {d2, d1, d0});
        end
        checks++;
        if (serial_out !== 1'b1) begin
            errors++; $display("FAIL reset_sout_load: got %b want 1", serial_out);
        end
        mode = 1'b0;
        tick(1);
        checks++;
        if (serial_out !== 1'b0) begin
            errors++; $display("FAIL reset_sout_noload: got %b want 0", serial_out);
        end
`ifdef DD_DONE_EN
        checks++;
        if (done !== 1'b0) begin
            errors++; $display("FAIL reset_done: got %b want 0", done);
        end
`endif
    endtask

    task automatic test_convert(input logic [7:0] val, input logic [11:0] exp, input string nm);
        load_and_convert(val);
        checks++;
        if ({d2, d1, d0} !== exp) begin
            errors++; $display("FAIL convert_%s: got %h want %h", nm, {d2, d1, d0}, exp);
        end
`ifdef DD_DONE_EN
        checks++;
        if (done !== 1'b1) begin
            errors++; $display("FAIL done_%s: got %b want 1", nm, done);
        end
`endif
    endtask

    task automatic test_serial_out;
        logic [7:0] exp_bits;
        exp_bits = 8'hB3;
        clear_bar = 1'b0; mode = 1'b1; parallel_in = 8'hB3; serial_in = 1'b0;
        tick(2);
        clear_bar = 1'b1; mode = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            checks++;
            if (serial_out !== exp_bits[i]) begin
                errors++; $display("FAIL sout_bit%0d: got %b want %b", i, serial_out, exp_bits[i]);
            end
            tick(1);
        end
    endtask

    task automatic test_hold;
        load_and_convert(8'hAA);
        for (int i = 0; i < 20; i++) begin
            serial_in = i[0];
            tick(1);
        end
        checks++;
        if ({d2, d1, d0} !== 12'h170) begin
            errors++; $display("FAIL hold_aa: got %h want 170", {d2, d1, d0});
        end
    endtask

    task automatic test_preset;
        clear_bar = 1'b1; preset_bar = 1'b0; mode = 1'b0; serial_in = 1'b0;
        tick(1);
        checks++;
        if (serial_out !== 1'b1 || {d2, d1, d0} !== 12'h000) begin
            errors++;
            $display("FAIL preset_state: got sout=%b dig=%h want 1/000", serial_out, {d2, d1, d0});
        end
        preset_bar = 1'b1;
        tick(8);
        checks++;
        if ({d2, d1, d0} !== 12'h255) begin
            errors++; $display("FAIL preset_convert: got %h want 255", {d2, d1, d0});
        end
    endtask

    task automatic test_abort;
        clear_bar = 1'b0; mode = 1'b1; parallel_in = 8'hB3; serial_in = 1'b0;
        tick(2);
        clear_bar = 1'b1; mode = 1'b0;
        tick(4);
        // After four steps of 1011_0011 the partial value is decimal 11.
        checks++;
        if ({d2, d1, d0} !== 12'h011) begin
            errors++; $display("FAIL abort_partial: got %h want 011", {d2, d1, d0});
        end
        clear_bar = 1'b0;
        tick(1);
        checks++;
        if ({d2, d1, d0} !== 12'h000 || serial_out !== 1'b0) begin
            errors++;
            $display("FAIL abort_clear: got dig=%h sout=%b want 000/0", {d2, d1, d0}, serial_out);
        end
`ifdef DD_DONE_EN
        checks++;
        if (done !== 1'b0) begin
            errors++; $display("FAIL abort_done: got %b want 0", done);
        end
`endif
        clear_bar = 1'b1;
        tick(10);
        checks++;
        if ({d2, d1, d0} !== 12'h000) begin
            errors++; $display("FAIL abort_zero_conv: got %h want 000", {d2, d1, d0});
        end
    endtask

    task automatic test_restart;
        clear_bar = 1'b0; mode = 1'b1; parallel_in = 8'hB3; serial_in = 1'b0;
        tick(2);
        clear_bar = 1'b1; mode = 1'b0;
        tick(3);
        mode = 1'b1; parallel_in = 8'h63;
        tick(1);
        checks++;
        if ({d2, d1, d0} !== 12'h000) begin
            errors++; $display("FAIL restart_clear: got %h want 000", {d2, d1, d0});
        end
        mode = 1'b0;
        tick(8);
        checks++;
        if ({d2, d1, d0} !== 12'h099) begin
            errors++; $display("FAIL restart_convert: got %h want 099", {d2, d1, d0});
        end
    endtask

    initial begin
        test_reset();
        test_convert(8'hB3, 12'h179, "b3");
        test_convert(8'h11, 12'h017, "11");
        test_convert(8'hAA, 12'h170, "aa");
        test_convert(8'h00, 12'h000, "00");
        test_convert(8'hFF, 12'h255, "ff");
        test_convert(8'h63, 12'h099, "63");
        test_serial_out();
        test_hold();
        test_preset();
        test_abort();
        test_restart();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
